// File: rtl/salu_instr_pkg.sv
// Scalar-ALU instruction types shared by the issue stage, the dispatcher
// and the compute units, plus the unit-map type used to bind ops to units.
package salu_instr_pkg;

  localparam int SALU_DATA_W    = 32;
  localparam int SALU_SGPR_W    = 5;
  localparam int SALU_TAG_W     = 8;
  // Upper bound on attached compute units; the unit map is sized to this
  localparam int SALU_MAX_UNITS = 4;

  typedef enum logic [3:0] {
    nop_op = 4'd0,
    add_op = 4'd1,
    sub_op = 4'd2,
    and_op = 4'd3,
    or_op  = 4'd4,
    xor_op = 4'd5
  } salu_op_t;

  typedef struct packed {
    salu_op_t salu_op;
  } salu_common_params_t;

  typedef struct packed {
    salu_common_params_t common_params;
  } salu_params_t;

  typedef struct packed {
    logic [SALU_SGPR_W-1:0] addr;
    logic [SALU_DATA_W-1:0] val;
  } salu_wr_req_t;

  // One issued scalar instruction: op, two source operands, the SGPR write
  // request that the compute unit fills in, and an issue tag
  typedef struct packed {
    salu_params_t                salu_params;
    logic [1:0][SALU_DATA_W-1:0] val;
    salu_wr_req_t                wr_req;
    logic [SALU_TAG_W-1:0]       tag;
  } salu_issued_instr_t;

  // Op served by each unit; only the first NUM_UNITS entries are decoded
  typedef salu_op_t salu_unit_map_t [SALU_MAX_UNITS];

  // Width of a unit index, never narrower than one bit
  function automatic int salu_unit_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/salu_order_fifo.sv
// Circular FIFO of compute-unit indices recording dispatch order so results
// can be retired in issue order. Depth must be a power of two, at least 2.
module salu_order_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_idx,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: the pointers decide which slots are live
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_idx;
  end

endmodule

// File: rtl/salu_dispatch.sv
// Scalar-ALU dispatcher: steers each issued instruction to the compute unit
// that serves its op and retires unit results to writeback in issue order.
module salu_dispatch
  import salu_instr_pkg::*;
#(
  parameter int             NUM_UNITS    = 2,
  // Entries beyond NUM_UNITS are ignored; mapped entries must be unique
  parameter salu_unit_map_t UNIT_OPS     = '{add_op, sub_op, nop_op, nop_op},
  parameter int             MAX_INFLIGHT = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            issue_valid,
  output logic                            issue_ready,
  input  salu_issued_instr_t              issue_data,
  output logic [NUM_UNITS-1:0]            unit_req_valid,
  input  logic [NUM_UNITS-1:0]            unit_req_ready,
  output salu_issued_instr_t              unit_req_data [NUM_UNITS],
  input  logic [NUM_UNITS-1:0]            unit_resp_valid,
  output logic [NUM_UNITS-1:0]            unit_resp_ready,
  input  salu_issued_instr_t              unit_resp_data [NUM_UNITS],
  output logic                            wb_valid,
  input  logic                            wb_ready,
  output salu_issued_instr_t              wb_data,
  output logic                            illegal_op,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight,
  output logic                            busy
);

  localparam int IDX_W = salu_unit_idx_w(NUM_UNITS);

  salu_op_t         op;
  logic             hit;
  logic [IDX_W-1:0] sel;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [IDX_W-1:0] head;

  assign op = issue_data.salu_params.common_params.salu_op;

  // Decode the issued op into the index of the unit that serves it
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (UNIT_OPS[i] == op) begin
        hit = 1'b1;
        sel = IDX_W'(i);
      end
    end
  end

  // Unmapped ops are always accepted so they drain; mapped ops wait for the
  // target unit and a free order slot (full depends only on registered state)
  always_comb begin
    issue_ready = 1'b1;
    if (hit) issue_ready = unit_req_ready[sel] && !full;
  end

  assign push = issue_valid && hit && issue_ready;

  // Present the request only to the selected unit; data is broadcast
  always_comb begin
    unit_req_valid = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      unit_req_valid[i] = issue_valid && hit && (sel == IDX_W'(i)) && !full;
      unit_req_data[i]  = issue_data;
    end
  end

  // Only the unit at the head of the order queue may hand over a result;
  // every other unit is held off so nothing is reordered or lost
  always_comb begin
    unit_resp_ready = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      unit_resp_ready[i] = !empty && (head == IDX_W'(i)) && wb_ready;
    end
  end

  assign wb_valid = !empty && unit_resp_valid[head];
  assign wb_data  = unit_resp_data[head];
  assign pop      = wb_valid && wb_ready;
  assign busy     = !empty;

  salu_order_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .WIDTH (IDX_W)
  ) u_order_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_idx (sel),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (inflight)
  );

  // Flag for one cycle that an unmapped instruction was accepted and dropped
  always_ff @(posedge clk) begin
    if (!rst_n) illegal_op <= 1'b0;
    else        illegal_op <= issue_valid && !hit;
  end

endmodule

// File: tb/tb_salu_dispatch.sv
// Self-checking bench for salu_dispatch: directed scenarios plus random
// traffic, compared every cycle against an in-order reference model.
module tb_salu_dispatch;
  import salu_instr_pkg::*;

  localparam int NU   = 2;
  localparam int MAXI = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic issue_valid;
  logic issue_ready;
  salu_issued_instr_t issue_data;
  logic [NU-1:0] unit_req_valid;
  logic [NU-1:0] unit_req_ready;
  salu_issued_instr_t unit_req_data [NU];
  logic [NU-1:0] unit_resp_valid;
  logic [NU-1:0] unit_resp_ready;
  salu_issued_instr_t unit_resp_data [NU];
  logic wb_valid;
  logic wb_ready;
  salu_issued_instr_t wb_data;
  logic illegal_op;
  logic [$clog2(MAXI):0] inflight;
  logic busy;

  always #5 clk = ~clk;

  salu_dispatch #(
    .NUM_UNITS    (NU),
    .MAX_INFLIGHT (MAXI)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .issue_valid     (issue_valid),
    .issue_ready     (issue_ready),
    .issue_data      (issue_data),
    .unit_req_valid  (unit_req_valid),
    .unit_req_ready  (unit_req_ready),
    .unit_req_data   (unit_req_data),
    .unit_resp_valid (unit_resp_valid),
    .unit_resp_ready (unit_resp_ready),
    .unit_resp_data  (unit_resp_data),
    .wb_valid        (wb_valid),
    .wb_ready        (wb_ready),
    .wb_data         (wb_data),
    .illegal_op      (illegal_op),
    .inflight        (inflight),
    .busy            (busy)
  );

  // Reference model: instructions owed to writeback, oldest first
  typedef struct {
    int                 unit;
    salu_issued_instr_t result;
  } exp_t;

  // Behavioural compute units: in-flight entries tagged with owning unit
  typedef struct {
    int                 unit;
    salu_issued_instr_t data;
    int                 due;
  } unit_ent_t;

  exp_t       exp_q[$];
  unit_ent_t  ue[$];
  int         wb_log[$];
  salu_op_t   bench_op [NU];
  int         bench_lat [NU];
  int         cyc;
  int         n_checks;
  int         n_fail;
  int         dut_wb_beats;
  logic       exp_illegal;
  logic       checks_on;
  logic       dut_issue_fire;
  logic [7:0] tag_cnt;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int op_unit(input salu_op_t op);
    for (int i = 0; i < NU; i++) if (bench_op[i] == op) return i;
    return -1;
  endfunction

  // Architectural result of an instruction, from its op
  function automatic salu_issued_instr_t ref_result(input salu_issued_instr_t d);
    salu_issued_instr_t r;
    r = d;
    case (d.salu_params.common_params.salu_op)
      add_op:  r.wr_req.val = d.val[0] + d.val[1];
      sub_op:  r.wr_req.val = d.val[0] - d.val[1];
      default: r.wr_req.val = d.wr_req.val;
    endcase
    return r;
  endfunction

  // What a unit produces: it applies its own op whatever it was sent
  function automatic salu_issued_instr_t unit_compute(input int i, input salu_issued_instr_t d);
    salu_issued_instr_t r;
    r = d;
    if (bench_op[i] == add_op) r.wr_req.val = d.val[0] + d.val[1];
    else                       r.wr_req.val = d.val[0] - d.val[1];
    return r;
  endfunction

  task automatic applyStimulus(input logic v, input salu_op_t op, input logic [31:0] a,
                               input logic [31:0] b, input logic [NU-1:0] rq, input logic wr);
    issue_valid = v;
    issue_data = '0;
    issue_data.salu_params.common_params.salu_op = op;
    issue_data.val[0] = a;
    issue_data.val[1] = b;
    issue_data.wr_req.addr = 5'($urandom_range(0, 31));
    issue_data.tag = tag_cnt;
    tag_cnt = tag_cnt + 8'd1;
    unit_req_ready = rq;
    wb_ready = wr;
  endtask

  task automatic drive_units();
    logic [NU-1:0] seen;
    seen = '0;
    for (int i = 0; i < NU; i++) begin
      unit_resp_valid[i] = 1'b0;
      unit_resp_data[i] = '0;
    end
    for (int j = 0; j < ue.size(); j++) begin
      if (!seen[ue[j].unit]) begin
        seen[ue[j].unit] = 1'b1;
        if (ue[j].due <= cyc) begin
          unit_resp_valid[ue[j].unit] = 1'b1;
          unit_resp_data[ue[j].unit] = ue[j].data;
        end
      end
    end
  endtask

  task automatic checkCycle(input int u, input logic hit, input logic exp_ready);
    logic [NU-1:0] ev;
    logic [NU-1:0] er;
    logic ewv;
    int hu;
    hu = (exp_q.size() > 0) ? exp_q[0].unit : -1;
    for (int i = 0; i < NU; i++) begin
      ev[i] = issue_valid && hit && (u == i) && (exp_q.size() < MAXI);
      er[i] = (hu == i) && wb_ready;
    end
    ewv = (hu >= 0) ? unit_resp_valid[hu] : 1'b0;
    checkOutput("issue_ready", issue_ready, exp_ready);
    checkOutput("unit_req_valid", unit_req_valid, ev);
    checkOutput("unit_resp_ready", unit_resp_ready, er);
    checkOutput("wb_valid", wb_valid, ewv);
    if (ewv) checkOutput("wb_data", wb_data, exp_q[0].result);
    checkOutput("inflight", inflight, exp_q.size());
    checkOutput("busy", busy, exp_q.size() != 0);
    checkOutput("illegal_op", illegal_op, exp_illegal);
  endtask

  // One clock: settle, compare, record handshakes, advance model
  task automatic tick();
    int u;
    int hu;
    logic hit;
    logic exp_ready;
    logic issue_fire;
    logic wb_fire;
    unit_ent_t e;
    exp_t x;
    drive_units();
    #1;
    u = op_unit(issue_data.salu_params.common_params.salu_op);
    hit = (u >= 0);
    exp_ready = hit ? (unit_req_ready[u] && (exp_q.size() < MAXI)) : 1'b1;
    if (checks_on) checkCycle(u, hit, exp_ready);
    issue_fire = issue_valid && exp_ready;
    hu = (exp_q.size() > 0) ? exp_q[0].unit : -1;
    wb_fire = (hu >= 0) && unit_resp_valid[hu] && wb_ready;
    dut_issue_fire = issue_valid && issue_ready;
    if (wb_valid && wb_ready) begin
      dut_wb_beats++;
      wb_log.push_back(int'(wb_data.wr_req.val));
    end
    for (int i = 0; i < NU; i++) begin
      if (unit_resp_valid[i] && unit_resp_ready[i]) begin
        for (int j = 0; j < ue.size(); j++) begin
          if (ue[j].unit == i) begin
            ue.delete(j);
            break;
          end
        end
      end
    end
    for (int i = 0; i < NU; i++) begin
      if (unit_req_valid[i] && unit_req_ready[i]) begin
        e.unit = i;
        e.data = unit_compute(i, unit_req_data[i]);
        e.due  = cyc + bench_lat[i];
        ue.push_back(e);
      end
    end
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      ue.delete();
      exp_illegal = 1'b0;
      checks_on = 1'b1;
    end else begin
      if (issue_fire && hit) begin
        x.unit = u;
        x.result = ref_result(issue_data);
        exp_q.push_back(x);
      end
      if (wb_fire) void'(exp_q.pop_front());
      exp_illegal = issue_valid && !hit;
    end
    #1;
  endtask

  task automatic idle(input int n, input logic wr);
    applyStimulus(1'b0, nop_op, 32'd0, 32'd0, '1, wr);
    repeat (n) tick();
  endtask

  task automatic drain();
    applyStimulus(1'b0, nop_op, 32'd0, 32'd0, '1, 1'b1);
    for (int k = 0; k < 200 && exp_q.size() > 0; k++) tick();
    tick();
    checkOutput("drain_inflight", inflight, 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    dut_wb_beats = 0;
    exp_illegal = 1'b0;
    checks_on = 1'b0;
    tag_cnt = 8'd0;
    bench_op[0] = add_op;
    bench_op[1] = sub_op;
    bench_lat[0] = 2;
    bench_lat[1] = 1;

    // Reset
    rst_n = 1'b0;
    applyStimulus(1'b0, nop_op, 32'd0, 32'd0, '1, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    checkOutput("rst_inflight", inflight, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_illegal", illegal_op, 0);
    checkOutput("rst_wb_valid", wb_valid, 0);
    checkOutput("rst_resp_ready", unit_resp_ready, 0);

    // Single add 5 + 7 through a two-cycle unit
    wb_log.delete();
    dut_wb_beats = 0;
    applyStimulus(1'b1, add_op, 32'd5, 32'd7, '1, 1'b1);
    tick();
    checkOutput("single_inflight_1", inflight, 1);
    idle(5, 1'b1);
    checkOutput("single_beats", dut_wb_beats, 1);
    if (wb_log.size() > 0) checkOutput("single_value", wb_log[0], 12);
    checkOutput("single_inflight_0", inflight, 0);

    // Out-of-order completion: sub unit finishes before add unit
    bench_lat[0] = 4;
    bench_lat[1] = 1;
    wb_log.delete();
    applyStimulus(1'b1, add_op, 32'd1, 32'd2, '1, 1'b1);
    tick();
    applyStimulus(1'b1, sub_op, 32'd10, 32'd3, '1, 1'b1);
    tick();
    idle(1, 1'b1);
    checkOutput("ooo_hold", unit_resp_ready[1], 1'b0);
    idle(7, 1'b1);
    checkOutput("ooo_count", wb_log.size(), 2);
    if (wb_log.size() >= 2) begin
      checkOutput("ooo_first", wb_log[0], 3);
      checkOutput("ooo_second", wb_log[1], 7);
    end

    // Full: eight accepted, ninth stalls until a pop has retired
    bench_lat[0] = 1;
    for (int k = 0; k < MAXI; k++) begin
      applyStimulus(1'b1, add_op, 32'(k), 32'd100, '1, 1'b0);
      tick();
      checkOutput($sformatf("full_accept_%0d", k), dut_issue_fire, 1'b1);
    end
    applyStimulus(1'b1, add_op, 32'd8, 32'd100, '1, 1'b0);
    tick();
    checkOutput("full_ninth_stall", dut_issue_fire, 1'b0);
    checkOutput("full_inflight", inflight, MAXI);
    wb_ready = 1'b1;
    tick();
    checkOutput("full_pop_blocks_push", dut_issue_fire, 1'b0);
    checkOutput("full_after_pop", inflight, MAXI - 1);
    wb_ready = 1'b0;
    tick();
    checkOutput("full_ninth_accept", dut_issue_fire, 1'b1);
    drain();

    // Illegal op is swallowed with a one-cycle flag
    applyStimulus(1'b1, and_op, 32'd4, 32'd4, '1, 1'b1);
    tick();
    checkOutput("illegal_accept", dut_issue_fire, 1'b1);
    checkOutput("illegal_pulse", illegal_op, 1'b1);
    checkOutput("illegal_inflight", inflight, 0);
    idle(1, 1'b1);
    checkOutput("illegal_clear", illegal_op, 1'b0);

    // Writeback backpressure with a pending head result
    bench_lat[0] = 2;
    applyStimulus(1'b1, add_op, 32'h11, 32'h22, '1, 1'b0);
    tick();
    idle(2, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput($sformatf("bp_valid_%0d", k), wb_valid, 1'b1);
      checkOutput($sformatf("bp_data_%0d", k), wb_data.wr_req.val, 32'h33);
      checkOutput($sformatf("bp_inflight_%0d", k), inflight, 1);
    end
    drain();

    // Reset with three results outstanding
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, add_op, 32'(k), 32'd1, '1, 1'b0);
      tick();
    end
    checkOutput("rmid_pre", inflight, 3);
    rst_n = 1'b0;
    applyStimulus(1'b0, nop_op, 32'd0, 32'd0, '1, 1'b0);
    tick();
    rst_n = 1'b1;
    checkOutput("rmid_inflight", inflight, 0);
    checkOutput("rmid_busy", busy, 1'b0);
    checkOutput("rmid_wb_valid", wb_valid, 1'b0);
    wb_log.delete();
    applyStimulus(1'b1, add_op, 32'd20, 32'd22, '1, 1'b1);
    tick();
    idle(5, 1'b1);
    checkOutput("rmid_post_count", wb_log.size(), 1);
    if (wb_log.size() > 0) checkOutput("rmid_post_value", wb_log[0], 42);

    // Random traffic; a stalled instruction is held unchanged
    begin
      salu_op_t op_pool [6];
      op_pool = '{add_op, sub_op, add_op, sub_op, and_op, xor_op};
      bench_lat[0] = $urandom_range(1, 4);
      bench_lat[1] = $urandom_range(1, 4);
      for (int k = 0; k < 600; k++) begin
        if (issue_valid && !dut_issue_fire) begin
          unit_req_ready = NU'($urandom_range(0, 3));
          wb_ready = ($urandom_range(0, 9) < 7);
        end else begin
          applyStimulus($urandom_range(0, 3) != 0, op_pool[$urandom_range(0, 5)],
                        $urandom, $urandom, NU'($urandom_range(0, 3)),
                        $urandom_range(0, 9) < 7);
        end
        tick();
      end
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/salu_dispatch.md
# salu_dispatch

Scalar-ALU dispatcher and writeback sequencer. It accepts issued scalar instructions on one decoupled stream and steers each to the per-operation `salu_compute` unit whose op matches. It then returns results to the SGPR writeback path strictly in issue order, regardless of per-unit pipeline depth. It sits between the scalar issue stage and the bank of `salu_compute` instances.

## Interface
- `NUM_UNITS`, default 2: number of attached compute units.
- `UNIT_OPS`, default `'{add_op, sub_op}`: array of `NUM_UNITS` op codes; entry i is the op served by unit i. Entries must be unique.
- `MAX_INFLIGHT`, default 8: order-queue depth, a power of two, at least 2.
- `clk` input, 1 bit: clock.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `issue` (decoupled_intr.slave): incoming instruction; data is `salu_issued_instr_t`.
- `unit_req[NUM_UNITS]` (decoupled_intr.master): instruction to unit i.
- `unit_resp[NUM_UNITS]` (decoupled_intr.slave): result from unit i.
- `wb` (decoupled_intr.master): in-order result to writeback; data is `salu_issued_instr_t`.
- `illegal_op` output, 1 bit: one-cycle pulse when an instruction with an unmapped op was dropped.
- `inflight` output, $clog2(MAX_INFLIGHT)+1 bits: number of dispatched results not yet written back.
- `busy` output, 1 bit: `inflight != 0`.

## Operation
- **Decode.** `sel` is the index i where `UNIT_OPS[i] == issue.data.salu_params.common_params.salu_op`. `hit` is set if any unit matches.
- **Dispatch.**
  - `unit_req[i].valid = issue.valid && hit && sel==i && !full`.
  - `unit_req[i].data = issue.data`, broadcast to all units.
  - `issue.ready = hit ? (unit_req[sel].ready && !full) : 1`.
  - On an `issue` handshake with `hit`, push `sel` into the order queue.
- **Illegal op.** An unmapped op is accepted (ready=1) and discarded. Nothing is pushed. `illegal_op` is registered high for the following cycle.
- **Order queue.** Circular FIFO of `$clog2(NUM_UNITS)`-bit unit indices with read pointer, write pointer and `inflight` counter.
  - `full = (inflight == MAX_INFLIGHT)`.
  - `empty = (inflight == 0)`.
  - Pointers wrap modulo `MAX_INFLIGHT`.
- **Writeback.**
  - `head` is the queue entry at the read pointer.
  - `wb.valid = !empty && unit_resp[head].valid`.
  - `wb.data = unit_resp[head].data`.
  - `unit_resp[i].ready = !empty && head==i && wb.ready`.
  - A `wb` handshake pops the queue.
  - Results from non-head units are held in place by ready=0. They are never reordered and never dropped.
- **Simultaneous push and pop.** `inflight` is unchanged and both pointers advance.
- **Full.** Full blocks push even when a pop happens in the same cycle. There is no combinational path from `wb.ready` to `issue.ready`.
- **Empty.** `wb.valid` is 0. Any `unit_resp.valid` asserted while the queue is empty is ignored (ready=0).

## Timing
- Dispatch is combinational: zero added latency from `issue` to `unit_req`.
- Writeback is combinational from `unit_resp[head]` to `wb`: zero added latency.
- End-to-end latency is the unit's pipeline latency. Issue throughput is one instruction per cycle while the target unit is ready and the queue is not full.
- Reset values:
  - Pointers = 0, `inflight` = 0, `busy` = 0, `illegal_op` = 0.
  - All `unit_req.valid` = 0, `wb.valid` = 0, all `unit_resp.ready` = 0, since the queue is empty.
- Reset mid-operation clears the queue and discards in-flight tracking. The compute units share `rst_n` and flush in the same cycle.
- `issue.valid` with `issue.ready` low must hold data stable; the dispatcher does not latch it.

## Structure
- Additions to `salu_instr_pkg`:
  - `salu_unit_map_t`, the array-of-op typedef used for `UNIT_OPS`.
  - Localparam helper `salu_unit_idx_w(n)` returning `$clog2` clamped to at least 1.
- One sub-module, `salu_order_fifo`: parameterized index FIFO with push/pop, head, full, empty and count.
- Op decode, steering muxes and the `illegal_op` flop stay in `salu_dispatch`.

## Test plan
- **Single add.** Reset, then issue one add_op with val[0]=5, val[1]=7; unit 0 returns after 2 cycles. Required: exactly one `wb` beat with wr_req.val=12; `inflight` goes 0→1→0.
- **Out-of-order completion.** Issue add (cycle 0) then sub (cycle 1). The sub unit responds before the add unit. Required: `unit_resp[1].ready` stays 0 until the add result is written back; `wb` order is add then sub.
- **Full.** `MAX_INFLIGHT`=8, `wb.ready`=0, issue 9 add ops back to back. Required: 8 accepted, `issue.ready`=0 on the 9th, `inflight`=8. Raise `wb.ready`: one pop, and the 9th is accepted the following cycle.
- **Illegal op.** Issue an op not in `UNIT_OPS`. Required: accepted in 1 cycle, no `unit_req.valid`, `illegal_op`=1 on the next cycle only, `inflight` unchanged.
- **Backpressure.** Hold `wb.ready`=0 for 5 cycles with a head result pending. Required: `wb.valid`=1 and `wb.data` stable throughout; no pop.
- **Reset mid-flight.** Assert `rst_n`=0 with `inflight`=3. Required: the next cycle shows `inflight`=0, `wb.valid`=0, `busy`=0; a subsequent add is processed normally.
